i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
- Byte-level I2C master sequencer. Runs from clk27m and generates its own quarter-bit timing.
- Accepts START / WRITE / READ / STOP commands from a CPU-side register block and drives SCL/SDA as open-drain enables.
- Returns read data and ACK status through a one-cycle response strobe.
- Sits between the peripheral register file and the board I2C pads.

Parameters:
- CLK_DIV, 68: clk27m cycles per quarter bit period (27 MHz / (4 × 68) ≈ 99.3 kHz SCL). Legal range is ≥ 2.

Ports:
- clk27m  in  1  system clock, 27 MHz
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command; equals !busy
- cmd  in  2  00 START, 01 WRITE, 10 READ, 11 STOP
- wr_data  in  8  byte for WRITE, captured at accept
- rd_nack  in  1  READ only: 1 = send NACK on the 9th bit, 0 = send ACK; captured at accept
- rsp_valid  out  1  one-cycle pulse when a command completes
- rd_data  out  8  received byte, valid while rsp_valid is high after a READ
- ack_err  out  1  WRITE only: 1 = slave NACKed; updated together with rsp_valid
- busy  out  1  command in progress
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_i  in  1  SDA pad input, already synchronised externally

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, busy=0, cmd_ready=1, rsp_valid=0, rd_data=0, ack_err=0; quarter counter=0, phase=0, bit index=0, state=IDLE.
- Accept: a command is taken on the cycle with cmd_valid && cmd_ready. On the next edge busy=1, and cmd, wr_data and rd_nack are latched.
  - cmd_valid while busy is ignored; no queueing.
- Quarter timer:
  - Counts 0..CLK_DIV-1 while busy and is held at 0 when idle.
  - tick is asserted on the cycle where count == CLK_DIV-1.
  - Each phase (0..3) lasts exactly CLK_DIV cycles, and its line levels are held for the whole phase.
- States: IDLE, START, BIT, STOP. Line levels are listed as (scl_oe, sda_oe) per phase.
  - IDLE: outputs hold their last values; waits for accept, then moves to START, BIT or STOP according to cmd.
  - START: p0 (1, 0), p1 (0, 0), p2 (0, 1), p3 (1, 1).
    - This gives a valid repeated start from the SCL-low state left by a byte.
  - BIT: 9 bits, MSB first. Bits 0..7 are data, bit 8 is ACK.
    - p0 (1, d), p1 (0, d), p2 (0, d), p3 (1, d).
    - d = ~wr_data[7-i] for WRITE data bits.
    - d = 0 (released) for READ data bits and for the WRITE ACK bit.
    - d = ~rd_nack for the READ ACK bit.
    - sda_i is sampled on the tick that ends p2. READ data shifts into a shift register; on WRITE the ACK bit is stored.
  - STOP: p0 (1, 1), p1 (0, 1), p2 (0, 0), p3 (0, 0).
- Completion happens on the tick ending p3 of the last phase or bit.
  - Next edge: busy=0, cmd_ready=1 and rsp_valid=1 for exactly one cycle.
  - rd_data is updated for a READ; ack_err = sampled ACK bit for a WRITE.
  - rd_data and ack_err otherwise hold their values.
- Latency from the accept edge to rsp_valid: 4·CLK_DIV+1 cycles for START/STOP, 36·CLK_DIV+1 cycles for WRITE/READ.
- Back-to-back: a new command may be accepted in the rsp_valid cycle, and its phase 0 then starts on the following edge.
- Reset mid-operation: on the next edge every output returns to its reset value and both lines are released. The bus may be left mid-transaction; recovery is software's job (START then STOP).
- No clock stretching, no arbitration-loss detection.

Test Plan:
1. CLK_DIV=4, rst then START → scl_oe/sda_oe follow (1,0),(0,0),(0,1),(1,1), each held 4 cycles; rsp_valid pulses once, 17 cycles after accept.
2. WRITE wr_data=0xA5 with sda_i=0 on the ACK bit → sda_oe inverted pattern 0,1,0,1,1,0,1,0 during bits 0–7 and 0 on bit 8; ack_err=0; rsp_valid 145 cycles after accept.
3. WRITE 0x3C with sda_i=1 on the ACK bit → ack_err=1 at rsp_valid; a following WRITE with ACK returns ack_err=0.
4. READ with rd_nack=1 and sda_i presenting 0x5A MSB-first at each p2 sample → rd_data=0x5A at rsp_valid; sda_oe stays 0 for all 9 bits. Repeat with rd_nack=0 → sda_oe=1 on bit 8.
5. STOP after a byte → (1,1),(0,1),(0,0),(0,0); final lines released, busy=0. A cmd_valid pulse during busy produces no extra rsp_valid.
6. rst asserted at bit 4 of a WRITE → next edge scl_oe=0, sda_oe=0, busy=0, cmd_ready=1, rsp_valid never pulses; a subsequent START runs normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: executes START / WRITE / READ / STOP commands
// and drives SCL/SDA as open-drain pull-down enables with self-generated quarter-bit timing.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 68
) (
    input  logic       clk27m,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       rd_nack,
    output logic       rsp_valid,
    output logic [7:0] rd_data,
    output logic       ack_err,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BIT   = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rd_nack_q, rd_nack_d;
    logic [7:0]       shift_q, shift_d;
    logic             ack_bit_q, ack_bit_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             ack_err_q, ack_err_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;

    logic       tick;
    logic [1:0] phase_nxt;
    logic [3:0] bit_nxt;
    logic [1:0] disp_state;

    // Line levels {scl_oe, sda_oe} for a given state/phase; d is the SDA drive of the current bit.
    function automatic logic [1:0] line_levels(input logic [1:0] st, input logic [1:0] ph,
                                               input logic d);
        logic [1:0] lv;
        lv = 2'b00;
        case (st)
            S_START: case (ph)
                2'd0:    lv = 2'b10;
                2'd1:    lv = 2'b00;
                2'd2:    lv = 2'b01;
                default: lv = 2'b11;
            endcase
            S_BIT:   lv = {(ph == 2'd0) || (ph == 2'd3), d};
            S_STOP:  case (ph)
                2'd0:    lv = 2'b11;
                2'd1:    lv = 2'b01;
                default: lv = 2'b00;
            endcase
            default: lv = 2'b00;
        endcase
        return lv;
    endfunction

    function automatic logic sda_drive(input logic [1:0] c, input logic [3:0] idx,
                                       input logic [7:0] data, input logic nack);
        if (idx == 4'd8) return (c == CMD_READ) ? ~nack : 1'b0;
        if (c == CMD_WRITE) return ~data[3'd7 - idx[2:0]];
        return 1'b0;
    endfunction

    assign tick      = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign phase_nxt = phase_q + 2'd1;
    assign bit_nxt   = bit_q + 4'd1;

    always_comb begin
        case (cmd_q)
            CMD_START: disp_state = S_START;
            CMD_STOP:  disp_state = S_STOP;
            default:   disp_state = S_BIT;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        wr_data_d   = wr_data_q;
        rd_nack_d   = rd_nack_q;
        shift_d     = shift_q;
        ack_bit_d   = ack_bit_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rd_data_d   = rd_data_q;
        ack_err_d   = ack_err_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;

        if (!busy_q) begin
            cnt_d = '0;
            if (cmd_valid) begin
                busy_d    = 1'b1;
                cmd_d     = cmd;
                wr_data_d = wr_data;
                rd_nack_d = rd_nack;
            end
        end else if (state_q == S_IDLE) begin
            // Dispatch cycle: phase 0 of the latched command begins on the next edge.
            state_d = disp_state;
            phase_d = 2'd0;
            bit_d   = 4'd0;
            cnt_d   = '0;
            {scl_oe_d, sda_oe_d} = line_levels(disp_state, 2'd0,
                                               sda_drive(cmd_q, 4'd0, wr_data_q, rd_nack_q));
        end else begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                if (state_q == S_BIT && phase_q == 2'd2) begin
                    if (bit_q == 4'd8) ack_bit_d = sda_i;
                    else if (cmd_q == CMD_READ) shift_d = {shift_q[6:0], sda_i};
                end
                if (phase_q != 2'd3) begin
                    phase_d = phase_nxt;
                    {scl_oe_d, sda_oe_d} = line_levels(state_q, phase_nxt,
                                                       sda_drive(cmd_q, bit_q, wr_data_q, rd_nack_q));
                end else if (state_q == S_BIT && bit_q != 4'd8) begin
                    bit_d   = bit_nxt;
                    phase_d = 2'd0;
                    {scl_oe_d, sda_oe_d} = line_levels(S_BIT, 2'd0,
                                                       sda_drive(cmd_q, bit_nxt, wr_data_q, rd_nack_q));
                end else begin
                    // Completion: lines hold their last phase levels until the next command.
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    phase_d     = 2'd0;
                    bit_d       = 4'd0;
                    cnt_d       = '0;
                    if (cmd_q == CMD_READ)  rd_data_d = shift_q;
                    if (cmd_q == CMD_WRITE) ack_err_d = ack_bit_q;
                end
            end
        end
    end

    always_ff @(posedge clk27m) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 2'd0;
            bit_q       <= 4'd0;
            cnt_q       <= '0;
            cmd_q       <= CMD_START;
            wr_data_q   <= 8'h00;
            rd_nack_q   <= 1'b0;
            shift_q     <= 8'h00;
            ack_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_data_q   <= 8'h00;
            ack_err_q   <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            wr_data_q   <= wr_data_d;
            rd_nack_q   <= rd_nack_d;
            shift_q     <= shift_d;
            ack_bit_q   <= ack_bit_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rd_data_q   <= rd_data_d;
            ack_err_q   <= ack_err_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign cmd_ready = ~busy_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rd_data   = rd_data_q;
    assign ack_err   = ack_err_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: per-cycle expected line levels and responses are
// queued at command accept and compared on every falling edge.
module tb_i2c_master_ctrl;

    localparam int D = 4;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    logic       clk27m;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       rd_nack;
    logic       rsp_valid;
    logic [7:0] rd_data;
    logic       ack_err;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    i2c_master_ctrl #(.CLK_DIV(D)) dut (
        .clk27m    (clk27m),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .rd_nack   (rd_nack),
        .rsp_valid (rsp_valid),
        .rd_data   (rd_data),
        .ack_err   (ack_err),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    initial clk27m = 1'b0;
    always #5 clk27m = ~clk27m;

    // One entry per clock cycle after accept: chk = compare line levels, rsp = response cycle.
    typedef struct packed {
        logic chk;
        logic rsp;
        logic scl;
        logic sda;
        logic sda_in;
    } wave_t;

    typedef struct packed {
        logic       is_read;
        logic       is_write;
        logic [7:0] rd;
        logic       ack;
    } rsp_t;

    wave_t wave_q[$];
    rsp_t  rsp_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    logic last_scl = 1'b0;
    logic last_sda = 1'b0;
    logic [7:0] exp_rd  = 8'h00;
    logic       exp_ack = 1'b0;

    function automatic wave_t mk(input logic chk, input logic rsp, input logic scl,
                                 input logic sda, input logic sin);
        wave_t w;
        w.chk = chk; w.rsp = rsp; w.scl = scl; w.sda = sda; w.sda_in = sin;
        return w;
    endfunction

    task automatic push_expect(input logic [1:0] c, input logic [7:0] data, input logic nack,
                               input logic [7:0] rbyte, input logic ack_in);
        logic [1:0] start_lv [4];
        logic [1:0] stop_lv [4];
        logic [1:0] lv;
        logic       d;
        logic       sin;
        rsp_t       r;
        start_lv = '{2'b10, 2'b00, 2'b01, 2'b11};
        stop_lv  = '{2'b11, 2'b01, 2'b00, 2'b00};
        wave_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        if (c == C_START || c == C_STOP) begin
            for (int p = 0; p < 4; p++) begin
                lv = (c == C_START) ? start_lv[p] : stop_lv[p];
                repeat (D) wave_q.push_back(mk(1'b1, 1'b0, lv[1], lv[0], 1'b1));
            end
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (i < 8) begin
                    d   = (c == C_WRITE) ? ~data[7-i] : 1'b0;
                    sin = (c == C_READ) ? rbyte[7-i] : 1'b1;
                end else begin
                    d   = (c == C_READ) ? ~nack : 1'b0;
                    sin = (c == C_WRITE) ? ack_in : 1'b1;
                end
                for (int p = 0; p < 4; p++)
                    repeat (D) wave_q.push_back(mk(1'b1, 1'b0, (p == 0) || (p == 3), d, sin));
            end
        end
        wave_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        r.is_read  = (c == C_READ);
        r.is_write = (c == C_WRITE);
        r.rd       = rbyte;
        r.ack      = ack_in;
        rsp_q.push_back(r);
    endtask

    // Scoreboard monitor: pops one expected entry per cycle and compares all outputs.
    always @(negedge clk27m) begin
        wave_t e;
        rsp_t  r;
        logic  exp_busy;
        logic  exp_rsp;
        if (mon_en) begin
            exp_busy = 1'b0;
            exp_rsp  = 1'b0;
            if (wave_q.size() > 0) begin
                e = wave_q.pop_front();
                sda_i = e.sda_in;
                exp_busy = ~e.rsp;
                exp_rsp  = e.rsp;
                if (e.chk) begin
                    last_scl = e.scl;
                    last_sda = e.sda;
                end
                if (e.rsp && rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    if (r.is_read)  exp_rd  = r.rd;
                    if (r.is_write) exp_ack = r.ack;
                end
            end else begin
                sda_i = 1'b1;
            end
            n_checks += 7;
            if (scl_oe !== last_scl) begin
                n_fail++; $display("FAIL scl_oe @%0t: got %b expected %b", $time, scl_oe, last_scl);
            end
            if (sda_oe !== last_sda) begin
                n_fail++; $display("FAIL sda_oe @%0t: got %b expected %b", $time, sda_oe, last_sda);
            end
            if (busy !== exp_busy) begin
                n_fail++; $display("FAIL busy @%0t: got %b expected %b", $time, busy, exp_busy);
            end
            if (cmd_ready !== ~exp_busy) begin
                n_fail++; $display("FAIL cmd_ready @%0t: got %b expected %b", $time, cmd_ready, ~exp_busy);
            end
            if (rsp_valid !== exp_rsp) begin
                n_fail++; $display("FAIL rsp_valid @%0t: got %b expected %b", $time, rsp_valid, exp_rsp);
            end
            if (rd_data !== exp_rd) begin
                n_fail++; $display("FAIL rd_data @%0t: got %h expected %h", $time, rd_data, exp_rd);
            end
            if (ack_err !== exp_ack) begin
                n_fail++; $display("FAIL ack_err @%0t: got %b expected %b", $time, ack_err, exp_ack);
            end
        end
    end

    // Called just after a falling edge; drives one command for one rising edge.
    task automatic send(input logic [1:0] c, input logic [7:0] data, input logic nack,
                        input logic [7:0] rbyte, input logic ack_in);
        logic rdy;
        cmd_valid = 1'b1;
        cmd       = c;
        wr_data   = data;
        rd_nack   = nack;
        rdy       = cmd_ready;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++; $display("FAIL send_ready: got %b expected 1", rdy);
        end
        @(posedge clk27m);
        if (rdy === 1'b1) push_expect(c, data, nack, rbyte, ack_in);
        #1 cmd_valid = 1'b0;
    endtask

    // Returns just after the falling edge of the response cycle.
    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 * D + 20 && !done; k++) begin
            @(negedge clk27m);
            #1;
            if (wave_q.size() == 0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL %s_timeout: queue %0d entries left, expected 0", name, wave_q.size());
        end
    endtask

    task automatic gap();
        @(negedge clk27m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk27m);
        #1;
        n_checks += 7;
        if (scl_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_scl: got %b expected 0", scl_oe); end
        if (sda_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_sda: got %b expected 0", sda_oe); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got %b expected 0", rsp_valid); end
        if (rd_data !== 8'h00)  begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        if (ack_err !== 1'b0)   begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
        gap();
        rst    = 1'b0;
        mon_en = 1'b1;
        gap();
    endtask

    task automatic test_start();
        send(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
        wait_idle("start");
        gap();
    endtask

    task automatic test_write_ack();
        send(C_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0);
        wait_idle("write_a5");
        n_checks++;
        if (ack_err !== 1'b0) begin n_fail++; $display("FAIL write_a5_ack: got %b expected 0", ack_err); end
        gap();
    endtask

    task automatic test_write_nack();
        send(C_WRITE, 8'h3C, 1'b0, 8'h00, 1'b1);
        wait_idle("write_3c");
        n_checks++;
        if (ack_err !== 1'b1) begin n_fail++; $display("FAIL write_3c_nack: got %b expected 1", ack_err); end
        send(C_WRITE, 8'h81, 1'b0, 8'h00, 1'b0);
        wait_idle("write_81");
        n_checks++;
        if (ack_err !== 1'b0) begin n_fail++; $display("FAIL write_81_ack: got %b expected 0", ack_err); end
        gap();
    endtask

    task automatic test_read();
        send(C_READ, 8'h00, 1'b1, 8'h5A, 1'b0);
        wait_idle("read_5a");
        n_checks++;
        if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL read_5a: got %h expected 5a", rd_data); end
        gap();
        send(C_READ, 8'h00, 1'b0, 8'hC3, 1'b0);
        wait_idle("read_c3");
        n_checks++;
        if (rd_data !== 8'hC3) begin n_fail++; $display("FAIL read_c3: got %h expected c3", rd_data); end
        gap();
    endtask

    task automatic test_back_to_back();
        send(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
        wait_idle("b2b_start");
        send(C_WRITE, 8'h6E, 1'b0, 8'h00, 1'b1);
        wait_idle("b2b_write");
        send(C_READ, 8'h00, 1'b1, 8'h96, 1'b0);
        wait_idle("b2b_read");
        send(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
        wait_idle("b2b_stop");
        gap();
    endtask

    task automatic test_stop_ignore();
        send(C_WRITE, 8'h12, 1'b0, 8'h00, 1'b0);
        wait_idle("pre_stop_write");
        gap();
        send(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (5) @(negedge clk27m);
        #1;
        cmd_valid = 1'b1;
        cmd       = C_START;
        gap();
        cmd_valid = 1'b0;
        wait_idle("stop");
        gap();
        n_checks += 3;
        if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL stop_scl: got %b expected 0", scl_oe); end
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL stop_sda: got %b expected 0", sda_oe); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy); end
        repeat (4) gap();
    endtask

    task automatic test_reset_mid();
        send(C_WRITE, 8'hF0, 1'b0, 8'h00, 1'b0);
        repeat (16 * D + 3) @(negedge clk27m);
        #1;
        rst = 1'b1;
        wave_q.delete();
        rsp_q.delete();
        last_scl = 1'b0;
        last_sda = 1'b0;
        exp_rd   = 8'h00;
        exp_ack  = 1'b0;
        @(posedge clk27m);
        #1;
        n_checks += 5;
        if (scl_oe !== 1'b0)    begin n_fail++; $display("FAIL midrst_scl: got %b expected 0", scl_oe); end
        if (sda_oe !== 1'b0)    begin n_fail++; $display("FAIL midrst_sda: got %b expected 0", sda_oe); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp: got %b expected 0", rsp_valid); end
        gap();
        rst = 1'b0;
        repeat (40) gap();
        send(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
        wait_idle("post_reset_start");
        repeat (3) gap();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        wr_data   = 8'h00;
        rd_nack   = 1'b0;
        sda_i     = 1'b1;
        test_reset();
        test_start();
        test_write_ack();
        test_write_nack();
        test_read();
        test_back_to_back();
        test_stop_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
